// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite register slave and its masters:
// bus widths, the read-only ID address and the read/write FSM encodings.
package axi_lite_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] ID_ADDR = 4'hF;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_COMMIT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  function automatic logic is_id_addr(input logic [ADDR_W-1:0] addr);
    return addr == ID_ADDR;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite style read/write channel bundle between a master and the register slave.
interface axi_lite_if;
  import axi_lite_pkg::*;

  logic [ADDR_W-1:0] read_address;
  logic              AR_VALID;
  logic              AR_READY;
  logic [DATA_W-1:0] data_read;
  logic              R_VALID;
  logic              R_READY;
  logic [ADDR_W-1:0] write_address;
  logic              AW_VALID;
  logic              AW_READY;
  logic [DATA_W-1:0] data_write;
  logic              W_VALID;
  logic              W_READY;
  logic              B_VALID;
  logic              B_READY;

  modport master (
    output read_address, AR_VALID, R_READY,
    output write_address, AW_VALID, data_write, W_VALID, B_READY,
    input  AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID
  );

  modport slave (
    input  read_address, AR_VALID, R_READY,
    input  write_address, AW_VALID, data_write, W_VALID, B_READY,
    output AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// 16 x 8 register storage: one synchronous write port, one asynchronous read port.
// Address ID_ADDR is read-only and always returns ID_VALUE.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Writes to the ID address complete on the bus but leave storage untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
        mem[i] <= '0;
      end
    end else if (we && !is_id_addr(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = is_id_addr(raddr) ? ID_VALUE : mem[raddr];

endmodule

// File: rtl/axi_lite_slave.sv
// AXI-lite register slave: independent read and write FSMs in front of a
// 16 x 8 register file; every bus output comes straight from a flop.
module axi_lite_slave #(
  parameter int unsigned                     RD_WAIT  = 0,
  parameter logic [axi_lite_pkg::DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input logic       clk,
  input logic       rst,
  axi_lite_if.slave bus
);
  import axi_lite_pkg::*;

  localparam logic [3:0] RD_CNT_INIT = 4'(RD_WAIT);

  rd_state_t         rd_state, rd_state_nx;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
  logic [3:0]        rd_cnt, rd_cnt_nx;
  logic [DATA_W-1:0] rd_data_q, rd_data_nx;
  logic              r_valid_q, r_valid_nx;
  logic              ar_ready_q, ar_ready_nx;

  wr_state_t         wr_state, wr_state_nx;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nx;
  logic [DATA_W-1:0] wr_data, wr_data_nx;
  logic              aw_held, aw_held_nx;
  logic              w_held, w_held_nx;
  logic              aw_ready_q, aw_ready_nx;
  logic              w_ready_q, w_ready_nx;
  logic              b_valid_q, b_valid_nx;
  logic              aw_hs, w_hs;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  // In idle the read port looks at the incoming address so a zero-wait read
  // can load data at the very edge the address is accepted.
  assign rf_raddr = (rd_state == RD_IDLE) ? bus.read_address : rd_addr;

  axi_lite_regfile #(.ID_VALUE(ID_VALUE)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      rd_data_q  <= '0;
      r_valid_q  <= 1'b0;
      ar_ready_q <= 1'b1;
      wr_state   <= WR_IDLE;
      wr_addr    <= '0;
      wr_data    <= '0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
    end else begin
      rd_state   <= rd_state_nx;
      rd_addr    <= rd_addr_nx;
      rd_cnt     <= rd_cnt_nx;
      rd_data_q  <= rd_data_nx;
      r_valid_q  <= r_valid_nx;
      ar_ready_q <= ar_ready_nx;
      wr_state   <= wr_state_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      aw_held    <= aw_held_nx;
      w_held     <= w_held_nx;
      aw_ready_q <= aw_ready_nx;
      w_ready_q  <= w_ready_nx;
      b_valid_q  <= b_valid_nx;
    end
  end

  // The state name RD_WAIT is qualified because the module parameter shares it.
  always_comb begin
    rd_state_nx = rd_state;
    rd_addr_nx  = rd_addr;
    rd_cnt_nx   = rd_cnt;
    rd_data_nx  = rd_data_q;
    r_valid_nx  = r_valid_q;
    ar_ready_nx = ar_ready_q;
    case (rd_state)
      RD_IDLE: begin
        if (bus.AR_VALID && ar_ready_q) begin
          rd_addr_nx  = bus.read_address;
          ar_ready_nx = 1'b0;
          if (RD_WAIT == 0) begin
            rd_data_nx  = rf_rdata;
            r_valid_nx  = 1'b1;
            rd_state_nx = RD_DATA;
          end else begin
            rd_cnt_nx   = RD_CNT_INIT;
            rd_state_nx = axi_lite_pkg::RD_WAIT;
          end
        end
      end
      axi_lite_pkg::RD_WAIT: begin
        rd_cnt_nx = rd_cnt - 4'd1;
        if (rd_cnt == 4'd1) begin
          rd_data_nx  = rf_rdata;
          r_valid_nx  = 1'b1;
          rd_state_nx = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_valid_q && bus.R_READY) begin
          r_valid_nx  = 1'b0;
          ar_ready_nx = 1'b1;
          rd_state_nx = RD_IDLE;
        end
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  // Address and data are collected independently; commit once both are held.
  always_comb begin
    wr_state_nx = wr_state;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    aw_held_nx  = aw_held;
    w_held_nx   = w_held;
    aw_ready_nx = aw_ready_q;
    w_ready_nx  = w_ready_q;
    b_valid_nx  = b_valid_q;
    rf_we       = 1'b0;
    aw_hs       = bus.AW_VALID && aw_ready_q;
    w_hs        = bus.W_VALID && w_ready_q;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs) begin
          wr_addr_nx  = bus.write_address;
          aw_held_nx  = 1'b1;
          aw_ready_nx = 1'b0;
        end
        if (w_hs) begin
          wr_data_nx = bus.data_write;
          w_held_nx  = 1'b1;
          w_ready_nx = 1'b0;
        end
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          wr_state_nx = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        rf_we       = 1'b1;
        b_valid_nx  = 1'b1;
        wr_state_nx = WR_RESP;
      end
      WR_RESP: begin
        if (b_valid_q && bus.B_READY) begin
          b_valid_nx  = 1'b0;
          aw_held_nx  = 1'b0;
          w_held_nx   = 1'b0;
          aw_ready_nx = 1'b1;
          w_ready_nx  = 1'b1;
          wr_state_nx = WR_IDLE;
        end
      end
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  assign bus.AR_READY  = ar_ready_q;
  assign bus.data_read = rd_data_q;
  assign bus.R_VALID   = r_valid_q;
  assign bus.AW_READY  = aw_ready_q;
  assign bus.W_READY   = w_ready_q;
  assign bus.B_VALID   = b_valid_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Bench for axi_lite_slave: two instances (zero-wait and three-wait reads) driven
// through a virtual interface, checked against a plain register-array model.
module tb_axi_lite_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  axi_lite_if bus0();
  axi_lite_if bus3();

  axi_lite_slave #(.RD_WAIT(0), .ID_VALUE(8'hA5)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  axi_lite_slave #(.RD_WAIT(3), .ID_VALUE(8'hA5)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  virtual axi_lite_if vb;
  int         sel;
  int         lat;
  logic [7:0] mdl [2][16];

  typedef struct {
    bit         isRead;
    logic [3:0] addr;
    logic [7:0] data;
    int         mode;
    int         hold;
  } vec_t;

  vec_t       vecs [12];
  logic [3:0] ra;
  logic [7:0] rdat;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] modelRead(input logic [3:0] a);
    return (a == 4'hF) ? 8'hA5 : mdl[sel][a];
  endfunction

  task automatic useDut(input int s);
    sel = s;
    if (s == 0) begin
      vb  = bus0;
      lat = 0;
    end else begin
      vb  = bus3;
      lat = 3;
    end
  endtask

  task automatic clearInputs;
    vb.read_address  = '0;
    vb.AR_VALID      = 1'b0;
    vb.R_READY       = 1'b0;
    vb.write_address = '0;
    vb.AW_VALID      = 1'b0;
    vb.data_write    = '0;
    vb.W_VALID       = 1'b0;
    vb.B_READY       = 1'b0;
  endtask

  task automatic resetDut;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) mdl[s][a] = 8'h00;
    checkOutput("rst_ar_ready0", bus0.AR_READY, 1);
    checkOutput("rst_aw_ready0", bus0.AW_READY, 1);
    checkOutput("rst_w_ready0", bus0.W_READY, 1);
    checkOutput("rst_r_valid0", bus0.R_VALID, 0);
    checkOutput("rst_b_valid0", bus0.B_VALID, 0);
    checkOutput("rst_data_read0", bus0.data_read, 0);
    checkOutput("rst_ar_ready3", bus3.AR_READY, 1);
    checkOutput("rst_r_valid3", bus3.R_VALID, 0);
    checkOutput("rst_b_valid3", bus3.B_VALID, 0);
  endtask

  // mode 0: AW before W, mode 1: W before AW, otherwise both on one edge
  task automatic writeTxn(input logic [3:0] a, input logic [7:0] d, input int mode, input int bhold);
    checkOutput("wr_aw_ready_idle", vb.AW_READY, 1);
    checkOutput("wr_w_ready_idle", vb.W_READY, 1);
    vb.write_address = a;
    vb.data_write    = d;
    vb.B_READY       = 1'b0;
    if (mode == 0) begin
      vb.AW_VALID = 1'b1;
      step();
      vb.AW_VALID = 1'b0;
      checkOutput("wr_aw_ready_drop", vb.AW_READY, 0);
      checkOutput("wr_w_ready_keep", vb.W_READY, 1);
      vb.W_VALID = 1'b1;
      step();
      vb.W_VALID = 1'b0;
    end else if (mode == 1) begin
      vb.W_VALID = 1'b1;
      step();
      vb.W_VALID = 1'b0;
      checkOutput("wr_w_ready_drop", vb.W_READY, 0);
      checkOutput("wr_aw_ready_keep", vb.AW_READY, 1);
      vb.AW_VALID = 1'b1;
      step();
      vb.AW_VALID = 1'b0;
    end else begin
      vb.AW_VALID = 1'b1;
      vb.W_VALID  = 1'b1;
      step();
      vb.AW_VALID = 1'b0;
      vb.W_VALID  = 1'b0;
    end
    checkOutput("wr_aw_ready_low", vb.AW_READY, 0);
    checkOutput("wr_w_ready_low", vb.W_READY, 0);
    checkOutput("wr_b_early", vb.B_VALID, 0);
    step();
    checkOutput("wr_b_latency", vb.B_VALID, 1);
    for (int k = 0; k < bhold; k++) begin
      step();
      checkOutput("wr_b_hold", vb.B_VALID, 1);
      checkOutput("wr_aw_ready_hold", vb.AW_READY, 0);
      checkOutput("wr_w_ready_hold", vb.W_READY, 0);
    end
    vb.B_READY = 1'b1;
    step();
    vb.B_READY = 1'b0;
    checkOutput("wr_b_done", vb.B_VALID, 0);
    checkOutput("wr_aw_ready_back", vb.AW_READY, 1);
    checkOutput("wr_w_ready_back", vb.W_READY, 1);
    if (a != 4'hF) mdl[sel][a] = d;
  endtask

  task automatic readTxn(input logic [3:0] a, input logic [7:0] exp, input int rhold);
    checkOutput("rd_ar_ready_idle", vb.AR_READY, 1);
    vb.read_address = a;
    vb.AR_VALID     = 1'b1;
    vb.R_READY      = 1'b0;
    step();
    vb.AR_VALID = 1'b0;
    checkOutput("rd_ar_ready_drop", vb.AR_READY, 0);
    for (int i = 0; i < lat; i++) begin
      checkOutput("rd_r_early", vb.R_VALID, 0);
      step();
    end
    checkOutput("rd_r_latency", vb.R_VALID, 1);
    checkOutput("rd_data", vb.data_read, exp);
    for (int k = 0; k < rhold; k++) begin
      step();
      checkOutput("rd_r_hold", vb.R_VALID, 1);
      checkOutput("rd_data_hold", vb.data_read, exp);
    end
    vb.R_READY = 1'b1;
    step();
    vb.R_READY = 1'b0;
    checkOutput("rd_r_done", vb.R_VALID, 0);
    checkOutput("rd_ar_ready_back", vb.AR_READY, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isRead) readTxn(v.addr, v.data, v.hold);
    else          writeTxn(v.addr, v.data, v.mode, v.hold);
  endtask

  task automatic randomOps(input int n);
    for (int i = 0; i < n; i++) begin
      ra   = 4'($urandom_range(0, 15));
      rdat = 8'($urandom);
      if ($urandom_range(0, 1) == 0)
        writeTxn(ra, rdat, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        readTxn(ra, modelRead(ra), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'h2, 8'h3C, 0, 0};
    vecs[1]  = '{1'b1, 4'h2, 8'h3C, 0, 0};
    vecs[2]  = '{1'b0, 4'h7, 8'hFF, 2, 0};
    vecs[3]  = '{1'b1, 4'h7, 8'hFF, 0, 2};
    vecs[4]  = '{1'b0, 4'hF, 8'h00, 1, 0};
    vecs[5]  = '{1'b1, 4'hF, 8'hA5, 0, 0};
    vecs[6]  = '{1'b0, 4'h5, 8'h11, 0, 4};
    vecs[7]  = '{1'b1, 4'h5, 8'h11, 0, 0};
    vecs[8]  = '{1'b1, 4'h0, 8'h00, 0, 1};
    vecs[9]  = '{1'b0, 4'h0, 8'h81, 1, 1};
    vecs[10] = '{1'b1, 4'h0, 8'h81, 0, 0};
    vecs[11] = '{1'b1, 4'hE, 8'h00, 0, 0};

    useDut(3);
    clearInputs();
    useDut(0);
    clearInputs();
    resetDut();

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Second write presented while the first response is stalled.
    $display("[TB] stalled response blocks a second write");
    vb.write_address = 4'h3;
    vb.data_write    = 8'h42;
    vb.AW_VALID      = 1'b1;
    vb.W_VALID       = 1'b1;
    step();
    vb.write_address = 4'h4;
    vb.data_write    = 8'h99;
    step();
    checkOutput("stall_b_valid", vb.B_VALID, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("stall_b_hold", vb.B_VALID, 1);
      checkOutput("stall_aw_ready", vb.AW_READY, 0);
      checkOutput("stall_w_ready", vb.W_READY, 0);
    end
    vb.B_READY = 1'b1;
    step();
    vb.B_READY = 1'b0;
    checkOutput("stall_b_done", vb.B_VALID, 0);
    checkOutput("stall_aw_ready_back", vb.AW_READY, 1);
    step();
    vb.AW_VALID = 1'b0;
    vb.W_VALID  = 1'b0;
    checkOutput("second_aw_taken", vb.AW_READY, 0);
    checkOutput("second_w_taken", vb.W_READY, 0);
    step();
    checkOutput("second_b_valid", vb.B_VALID, 1);
    vb.B_READY = 1'b1;
    step();
    vb.B_READY = 1'b0;
    mdl[0][3] = 8'h42;
    mdl[0][4] = 8'h99;
    readTxn(4'h3, modelRead(4'h3), 0);
    readTxn(4'h4, modelRead(4'h4), 0);

    $display("[TB] three-wait reads of the ID register");
    useDut(1);
    readTxn(4'hF, 8'hA5, 5);
    writeTxn(4'hF, 8'h00, 2, 0);
    readTxn(4'hF, 8'hA5, 0);
    randomOps(30);
    useDut(0);
    randomOps(30);

    $display("[TB] read loads on the commit edge of a write to the same address");
    resetDut();
    vb.write_address = 4'h5;
    vb.data_write    = 8'h11;
    vb.AW_VALID      = 1'b1;
    vb.W_VALID       = 1'b1;
    step();
    vb.AW_VALID     = 1'b0;
    vb.W_VALID      = 1'b0;
    vb.read_address = 4'h5;
    vb.AR_VALID     = 1'b1;
    step();
    vb.AR_VALID = 1'b0;
    checkOutput("coll_r_valid", vb.R_VALID, 1);
    checkOutput("coll_old_data", vb.data_read, 8'h00);
    checkOutput("coll_b_valid", vb.B_VALID, 1);
    vb.R_READY = 1'b1;
    vb.B_READY = 1'b1;
    step();
    vb.R_READY = 1'b0;
    vb.B_READY = 1'b0;
    checkOutput("coll_r_done", vb.R_VALID, 0);
    checkOutput("coll_b_done", vb.B_VALID, 0);
    mdl[0][5] = 8'h11;
    readTxn(4'h5, modelRead(4'h5), 0);

    $display("[TB] reset during commit and read wait");
    useDut(1);
    writeTxn(4'h1, 8'h77, 2, 0);
    vb.write_address = 4'h4;
    vb.data_write    = 8'h55;
    vb.AW_VALID      = 1'b1;
    vb.W_VALID       = 1'b1;
    vb.read_address  = 4'h1;
    vb.AR_VALID      = 1'b1;
    step();
    vb.AW_VALID = 1'b0;
    vb.W_VALID  = 1'b0;
    vb.AR_VALID = 1'b0;
    vb.B_READY  = 1'b1;
    vb.R_READY  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vb.B_READY = 1'b0;
    vb.R_READY = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) mdl[s][a] = 8'h00;
    checkOutput("abort_ar_ready", vb.AR_READY, 1);
    checkOutput("abort_aw_ready", vb.AW_READY, 1);
    checkOutput("abort_w_ready", vb.W_READY, 1);
    checkOutput("abort_data_read", vb.data_read, 8'h00);
    for (int k = 0; k < 5; k++) begin
      checkOutput("abort_no_b", vb.B_VALID, 0);
      checkOutput("abort_no_r", vb.R_VALID, 0);
      step();
    end
    readTxn(4'h4, 8'h00, 0);
    readTxn(4'h1, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave.md
AXI_LITE_SLAVE -- requirements
Module: axi_lite_slave

Interface
REQ-001 Parameter RD_WAIT, default 0: wait cycles between AR handshake and R_VALID assertion (0..15).
REQ-002 Parameter ID_VALUE, default 8'hA5: constant returned by read-only address 4'hF.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 read_address  input  4  read address from master.
REQ-006 AR_VALID  input  1  read address valid.
REQ-007 AR_READY  output  1  slave can accept a read address.
REQ-008 data_read  output  8  read data to master.
REQ-009 R_VALID  output  1  data_read valid.
REQ-010 R_READY  input  1  master accepts read data.
REQ-011 write_address  input  4  write address from master.
REQ-012 AW_VALID  input  1  write address valid.
REQ-013 AW_READY  output  1  slave can accept a write address.
REQ-014 data_write  input  8  write data from master.
REQ-015 W_VALID  input  1  write data valid.
REQ-016 W_READY  output  1  slave can accept write data.
REQ-017 B_VALID  output  1  write response valid.
REQ-018 B_READY  input  1  master accepts write response.

Function
REQ-019 Storage: 16 x 8-bit registers; addresses 0..14 read/write; address 15 read-only, reads ID_VALUE, writes complete normally with no storage change.
REQ-020 Handshake on a channel occurs at a rising edge where VALID and READY are both 1; inputs sampled only at that edge.
REQ-021 All outputs registered; no combinational path from any input to any output.
REQ-022 Read FSM states RD_IDLE, RD_WAIT, RD_DATA; AR_READY=1 only in RD_IDLE.
REQ-023 RD_IDLE + AR handshake: latch address; RD_WAIT=0 -> RD_DATA with data_read loaded and R_VALID=1 at that same edge; else -> RD_WAIT with 4-bit counter loaded with RD_WAIT.
REQ-024 RD_WAIT: counter decrements each cycle; on edge where counter==1, load data_read, set R_VALID=1, -> RD_DATA.
REQ-025 RD_DATA: R_VALID and data_read held stable until R handshake; on that edge R_VALID=0, AR_READY=1, -> RD_IDLE.
REQ-026 Write FSM states WR_IDLE, WR_COMMIT, WR_RESP; AW and W captured independently in WR_IDLE, any order or same edge.
REQ-027 WR_IDLE: AW_READY=1 while no address held, W_READY=1 while no data held; each READY drops at the edge its handshake completes.
REQ-028 Edge where both address and data become held: -> WR_COMMIT.
REQ-029 WR_COMMIT (exactly one cycle): at its closing edge register written, B_VALID=1, -> WR_RESP.
REQ-030 WR_RESP: B_VALID held until B handshake; at that edge B_VALID=0, holdings cleared, AW_READY=W_READY=1, -> WR_IDLE.
REQ-031 Read and write FSMs independent and concurrent.
REQ-032 Read loading data_read from the address being written at the same edge returns the pre-write value.
REQ-033 Read latency (AR handshake edge to R_VALID high) = RD_WAIT edges, minimum 0 (same edge); write latency (last of AW/W handshake to B_VALID high) = 1 edge.

Reset
REQ-034 While rst=1 at an edge: registers 0..14 = 8'h00, data_read=8'h00, R_VALID=0, B_VALID=0, AR_READY=AW_READY=W_READY=1, FSMs to RD_IDLE/WR_IDLE, holdings and counter cleared.
REQ-035 Reset mid-transaction abandons it: no register write, no R/B response issued afterwards.
REQ-036 No handshake is recognised at an edge where rst=1.

Structure
REQ-037 Shared package axi_lite_pkg holds ADDR_W=4, DATA_W=8, ID_ADDR=4'hF, read/write state encodings; axi_master uses the same package.
REQ-038 Storage in sub-module axi_lite_regfile (16x8, one sync write port, one async read port, ID override at 4'hF); FSMs in axi_lite_slave.

Verification
REQ-039 Write 8'h3C to 4'h2 (AW then W), B_READY=1 -> B_VALID high 1 edge after W handshake; then read 4'h2, RD_WAIT=0 -> data_read=8'h3C, R_VALID on AR edge.
REQ-040 AW_VALID and W_VALID same edge, addr 4'h7, data 8'hFF -> both READYs drop together, single B response, read 4'h7 = 8'hFF.
REQ-041 RD_WAIT=3, read 4'hF with R_READY low 5 cycles -> R_VALID after 3 edges, data_read=8'hA5 held stable until R_READY; write 8'h00 to 4'hF -> B response, reads still 8'hA5.
REQ-042 B_READY held low 4 cycles -> B_VALID stays high, AW_READY/W_READY stay 0; second write accepted only after B handshake.
REQ-043 Write 8'h11 to 4'h5 commits same edge a read of 4'h5 loads data_read -> data_read=old 8'h00; subsequent read -> 8'h11.
REQ-044 rst pulsed while in WR_COMMIT and RD_WAIT -> no B_VALID, no R_VALID, all registers 8'h00, READYs 1.
